// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, decimal saturation limit helper and the nine-digit pattern.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } conv_state_e;

    // One BCD digit showing 9; replicated per digit to form the saturated display.
    localparam logic [3:0] BCD_NINE = 4'h9;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble nibble correction: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with start/busy/done handshake; results,
// blanking mask and overflow flag are held stable between conversions.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf
);

    localparam int SW = 4 * DIGITS + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_NINE}};
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    conv_state_e          state_q, state_d;
    logic [SW-1:0]        scratch_q, scratch_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [DIGITS-1:0]    blank_q, blank_d;
    logic                 ovf_q, ovf_d;

    logic [4*DIGITS-1:0]  bcd_adj;
    logic [SW-1:0]        scratch_adj;
    logic [4*DIGITS-1:0]  result;
    logic [DIGITS-1:0]    digit_nz;
    logic [DIGITS-1:0]    blank_calc;

    // Corrections act on pre-shift nibbles; the shift happens in the same step.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .nib_i (scratch_q[BIN_W + 4*gi +: 4]),
                .nib_o (bcd_adj[4*gi +: 4])
            );

            assign digit_nz[gi] = |result[4*gi +: 4];

            if (gi == 0) begin : g_units
                assign blank_calc[gi] = 1'b0;
            end else begin : g_upper
                assign blank_calc[gi] = ~|digit_nz[DIGITS-1:gi];
            end
        end
    endgenerate

    assign scratch_adj = {bcd_adj, scratch_q[BIN_W-1:0]};
    assign result      = ovf_pend_q ? ALL_NINES : scratch_q[SW-1:BIN_W];

    always_comb begin
        state_d    = state_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    scratch_d  = {{(4*DIGITS){1'b0}}, bin_in};
                    ovf_pend_d = 64'(bin_in) > LIMIT;
                    count_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = {scratch_adj[SW-2:0], 1'b0};
                count_d   = count_q + 1'b1;
                if (count_q == CW'(BIN_W - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                bcd_d   = result;
                blank_d = blank_calc;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            scratch_q  <= '0;
            count_q    <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BLANK_RST;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign blank   = blank_q;
    assign ovf     = ovf_q;

endmodule
